// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage pipeline: forwarding selects, load-use and branch-operand
// stalls, branch flush and memory-wait sequencing. Optional stall counter under `HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int BR_FLUSH_CYCLES = 1,
    parameter int MEM_WAIT_MAX    = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_is_branch,
    input  logic [4:0]  ex_num_write,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  mem_num_write,
    input  logic        mem_reg_write,
    input  logic [4:0]  wb_num_write,
    input  logic        wb_reg_write,
    input  logic        branch_taken,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_exe_flush,
    output logic [1:0]  s_forwardA3,
    output logic [1:0]  s_forwardB3,
    output logic [1:0]  s_forwardA2,
    output logic [1:0]  s_forwardB2,
    output logic        mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    typedef enum logic [1:0] {RUN, STALL, BR_FLUSH, MEM_WAIT} state_t;

    localparam logic [2:0]  FLUSH_LOAD = 3'(BR_FLUSH_CYCLES - 1);
    localparam logic [16:0] WAIT_LIMIT = 17'(MEM_WAIT_MAX);

    state_t      state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        br_pend_q, br_pend_d;
    logic        timeout_q, timeout_d;
    logic        ex_src_match, lu, bh, hazard;

    // Register 0 is hardwired to zero, so it never matches a destination.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic src_used, input logic [4:0] src,
                                           input logic near_we, input logic [4:0] near_num,
                                           input logic far_we, input logic [4:0] far_num);
        logic [1:0] sel;
        sel = 2'b00;
        if (src_used && near_we && reg_match(src, near_num))
            sel = 2'b01;
        else if (src_used && far_we && reg_match(src, far_num))
            sel = 2'b10;
        return sel;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        ex_src_match = reg_match(id_rs, ex_num_write) | (id_uses_rt & reg_match(id_rt, ex_num_write));
        lu           = ex_mem_read & ex_reg_write & ex_src_match;
        bh           = id_is_branch & ex_reg_write & ex_src_match;
        hazard       = lu | bh;
    end

    always_comb begin
        s_forwardA3 = 2'b00;
        s_forwardB3 = 2'b00;
        s_forwardA2 = 2'b00;
        s_forwardB2 = 2'b00;
        if (!reset) begin
            s_forwardA3 = fwd_sel(1'b1, id_rs, ex_reg_write, ex_num_write, mem_reg_write, mem_num_write);
            s_forwardB3 = fwd_sel(id_uses_rt, id_rt, ex_reg_write, ex_num_write, mem_reg_write, mem_num_write);
            s_forwardA2 = fwd_sel(1'b1, id_rs, mem_reg_write, mem_num_write, wb_reg_write, wb_num_write);
            s_forwardB2 = fwd_sel(id_uses_rt, id_rt, mem_reg_write, mem_num_write, wb_reg_write, wb_num_write);
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        br_pend_d   = br_pend_q;
        timeout_d   = timeout_q;
        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    state_d = MEM_WAIT;
                end else if (branch_taken) begin
                    state_d     = BR_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end else if (hazard) begin
                    state_d = STALL;
                end
            end
            STALL: begin
                if (mem_busy)
                    state_d = MEM_WAIT;
                else if (!hazard)
                    state_d = RUN;
            end
            BR_FLUSH: begin
                if (flush_cnt_q == 3'd0)
                    state_d = RUN;
                else
                    flush_cnt_d = flush_cnt_q - 3'd1;
            end
            MEM_WAIT: begin
                if (mem_busy) begin
                    wait_cnt_d = sat_inc(wait_cnt_q);
                    if ({1'b0, wait_cnt_d} > WAIT_LIMIT)
                        timeout_d = 1'b1;
                    if (branch_taken)
                        br_pend_d = 1'b1;
                end else begin
                    // A branch resolved while memory stalled the pipe is replayed on exit.
                    wait_cnt_d = 16'd0;
                    br_pend_d  = 1'b0;
                    if (br_pend_q || branch_taken) begin
                        state_d     = BR_FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_exe_flush = 1'b0;
        if (!reset) begin
            case (state_q)
                RUN: begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                end
                STALL: id_exe_flush = 1'b1;
                BR_FLUSH: begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    if_id_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_timeout = timeout_q & ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            flush_cnt_q <= 3'd0;
            wait_cnt_q  <= 16'd0;
            br_pend_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            br_pend_q   <= br_pend_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clock) begin
        if (reset)
            perf_q <= 32'd0;
        else if (state_q == STALL || state_q == MEM_WAIT)
            perf_q <= perf_q + 32'd1;
    end

    assign stall_cycles = reset ? 32'd0 : perf_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl with a counter-based reference model of the stall/flush/wait rules.
module tb_hazard_ctrl;
    localparam int BRC  = 2;
    localparam int WMAX = 255;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic [4:0] id_rs, id_rt, ex_num_write, mem_num_write, wb_num_write;
    logic       id_uses_rt, id_is_branch, ex_reg_write, ex_mem_read;
    logic       mem_reg_write, wb_reg_write, branch_taken, mem_busy;
    logic       pc_write, if_id_write, if_id_flush, id_exe_flush, mem_timeout;
    logic [1:0] s_forwardA3, s_forwardB3, s_forwardA2, s_forwardB2;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    hazard_ctrl #(.BR_FLUSH_CYCLES(BRC), .MEM_WAIT_MAX(WMAX)) dut (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
        .ex_num_write(ex_num_write), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_num_write(mem_num_write), .mem_reg_write(mem_reg_write),
        .wb_num_write(wb_num_write), .wb_reg_write(wb_reg_write),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_exe_flush(id_exe_flush), .s_forwardA3(s_forwardA3), .s_forwardB3(s_forwardB3),
        .s_forwardA2(s_forwardA2), .s_forwardB2(s_forwardB2), .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: what the pipeline is currently doing, kept as plain counters and flags.
    int          m_flush_left = 0;
    int          m_wait_len   = 0;
    bit          m_stalled    = 0;
    bit          m_waiting    = 0;
    bit          m_pend       = 0;
    bit          m_timeout    = 0;
    int unsigned m_perf       = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input bit used, input logic [4:0] src,
                                           input bit aw, input logic [4:0] an,
                                           input bit bw, input logic [4:0] bn);
        if (!used || src == 5'd0) return 2'd0;
        if (aw && an == src) return 2'd1;
        if (bw && bn == src) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit ref_hazard();
        bit dep;
        dep = ex_reg_write && ((id_rs != 0 && ex_num_write == id_rs) ||
                               (id_uses_rt && id_rt != 0 && ex_num_write == id_rt));
        return dep && (ex_mem_read || id_is_branch);
    endfunction

    task automatic settle();
        bit e_pc, e_ifw, e_ifl, e_idx;
        #2;
        e_pc = 1; e_ifw = 1; e_ifl = 0; e_idx = 0;
        if (m_waiting) begin
            e_pc = 0; e_ifw = 0;
        end else if (m_flush_left > 0) begin
            e_ifl = 1;
        end else if (m_stalled) begin
            e_pc = 0; e_ifw = 0; e_idx = 1;
        end
        if (reset) begin
            e_pc = 0; e_ifw = 0; e_ifl = 0; e_idx = 0;
        end
        chk("pc_write", 32'(pc_write), 32'(e_pc));
        if (reset || m_flush_left == 0)
            chk("if_id_write", 32'(if_id_write), 32'(e_ifw));
        chk("if_id_flush", 32'(if_id_flush), 32'(e_ifl));
        chk("id_exe_flush", 32'(id_exe_flush), 32'(e_idx));
        chk("fwdA3", 32'(s_forwardA3), reset ? 32'd0 :
            32'(ref_fwd(1, id_rs, ex_reg_write, ex_num_write, mem_reg_write, mem_num_write)));
        chk("fwdB3", 32'(s_forwardB3), reset ? 32'd0 :
            32'(ref_fwd(id_uses_rt, id_rt, ex_reg_write, ex_num_write, mem_reg_write, mem_num_write)));
        chk("fwdA2", 32'(s_forwardA2), reset ? 32'd0 :
            32'(ref_fwd(1, id_rs, mem_reg_write, mem_num_write, wb_reg_write, wb_num_write)));
        chk("fwdB2", 32'(s_forwardB2), reset ? 32'd0 :
            32'(ref_fwd(id_uses_rt, id_rt, mem_reg_write, mem_num_write, wb_reg_write, wb_num_write)));
        chk("mem_timeout", 32'(mem_timeout), reset ? 32'd0 : 32'(m_timeout));
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, reset ? 32'd0 : m_perf);
`endif
    endtask

    task automatic advance();
        if (reset) begin
            m_flush_left = 0; m_wait_len = 0; m_stalled = 0;
            m_waiting = 0; m_pend = 0; m_timeout = 0; m_perf = 0;
        end else begin
            if (m_stalled || m_waiting) m_perf++;
            if (m_waiting) begin
                if (mem_busy) begin
                    if (m_wait_len < 65535) m_wait_len++;
                    if (m_wait_len > WMAX) m_timeout = 1;
                    if (branch_taken) m_pend = 1;
                end else begin
                    m_waiting = 0;
                    m_wait_len = 0;
                    if (m_pend || branch_taken) m_flush_left = BRC;
                    m_pend = 0;
                end
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end else if (m_stalled) begin
                if (mem_busy) begin
                    m_stalled = 0;
                    m_waiting = 1;
                end else begin
                    m_stalled = ref_hazard();
                end
            end else begin
                if (mem_busy) m_waiting = 1;
                else if (branch_taken) m_flush_left = BRC;
                else m_stalled = ref_hazard();
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; id_is_branch = 0;
        ex_num_write = 0; ex_reg_write = 0; ex_mem_read = 0;
        mem_num_write = 0; mem_reg_write = 0; wb_num_write = 0; wb_reg_write = 0;
        branch_taken = 0; mem_busy = 0;
    endtask

    initial begin
        int burst;
        burst = 0;
        reset = 1;
        idle_inputs();
        @(negedge clock);
        settle();
        chk("rst_pc_write", 32'(pc_write), 32'd0);
        advance();
        tick();
        reset = 0;
        settle();
        chk("post_rst_pc_write", 32'(pc_write), 32'd1);
        advance();

        // Load-use: lw $2 in EX, add using $2 in ID.
        ex_mem_read = 1; ex_reg_write = 1; ex_num_write = 2; id_rs = 2;
        tick();
        ex_mem_read = 0; ex_reg_write = 0; mem_reg_write = 1; mem_num_write = 2;
        settle();
        chk("lu_stall_pc", 32'(pc_write), 32'd0);
        chk("lu_stall_bubble", 32'(id_exe_flush), 32'd1);
        advance();
        settle();
        chk("lu_resume_pc", 32'(pc_write), 32'd1);
        chk("lu_resume_fwdA3", 32'(s_forwardA3), 32'd2);
        advance();

        // EX beats MEM for forwarding; rt only when used; register 0 never forwards.
        idle_inputs();
        ex_reg_write = 1; mem_reg_write = 1; ex_num_write = 3; mem_num_write = 3;
        id_rt = 3; id_uses_rt = 1;
        settle();
        chk("fwdB3_ex_prio", 32'(s_forwardB3), 32'd1);
        advance();
        id_uses_rt = 0;
        settle();
        chk("fwdB3_unused", 32'(s_forwardB3), 32'd0);
        advance();
        id_uses_rt = 1; id_rt = 0; ex_num_write = 0; mem_num_write = 0;
        settle();
        chk("fwdB3_reg0", 32'(s_forwardB3), 32'd0);
        advance();

        // Taken branch: flush for BRC cycles with PC still advancing.
        idle_inputs();
        branch_taken = 1;
        tick();
        branch_taken = 0;
        for (int i = 0; i < BRC; i++) begin
            settle();
            chk("br_flush_on", 32'(if_id_flush), 32'd1);
            chk("br_flush_pc", 32'(pc_write), 32'd1);
            advance();
        end
        settle();
        chk("br_flush_off", 32'(if_id_flush), 32'd0);
        advance();

        // Long memory wait with a branch arriving mid-wait.
        for (int i = 0; i < 300; i++) begin
            mem_busy = 1;
            branch_taken = (i == 50);
            settle();
            chk("timeout_edge", 32'(mem_timeout), (i >= 257) ? 32'd1 : 32'd0);
            advance();
        end
        mem_busy = 0; branch_taken = 0;
        tick();
        settle();
        chk("wait_exit_branch", 32'(if_id_flush), 32'd1);
        chk("timeout_sticky", 32'(mem_timeout), 32'd1);
        advance();
        tick();
        tick();

        // Branch and load-use together, then reset in the middle of the flush.
        branch_taken = 1; ex_mem_read = 1; ex_reg_write = 1; ex_num_write = 2; id_rs = 2;
        tick();
        idle_inputs();
        settle();
        chk("br_over_lu_flush", 32'(if_id_flush), 32'd1);
        chk("br_over_lu_nobubble", 32'(id_exe_flush), 32'd0);
        reset = 1;
        settle();
        chk("rst_in_flush_pc", 32'(pc_write), 32'd0);
        chk("rst_in_flush_fl", 32'(if_id_flush), 32'd0);
        advance();
        reset = 0;
        settle();
        chk("rst_abandon_flush", 32'(if_id_flush), 32'd0);
        chk("rst_abandon_pc", 32'(pc_write), 32'd1);
        chk("rst_clears_timeout", 32'(mem_timeout), 32'd0);
        advance();

`ifdef HAZARD_PERF_CNT_EN
        reset = 1;
        tick();
        reset = 0;
        ex_mem_read = 1; ex_reg_write = 1; ex_num_write = 4; id_rs = 4;
        tick();
        idle_inputs();
        tick();
        for (int i = 0; i < 10; i++) begin
            mem_busy = 1;
            tick();
        end
        mem_busy = 0;
        tick();
        settle();
        chk("perf_11", stall_cycles, 32'd11);
        advance();
`endif

        for (int c = 0; c < 4000; c++) begin
            reset         = ($urandom_range(0, 299) == 0);
            id_rs         = 5'($urandom_range(0, 3));
            id_rt         = 5'($urandom_range(0, 3));
            ex_num_write  = 5'($urandom_range(0, 3));
            mem_num_write = 5'($urandom_range(0, 3));
            wb_num_write  = 5'($urandom_range(0, 3));
            id_uses_rt    = 1'($urandom_range(0, 1));
            ex_reg_write  = 1'($urandom_range(0, 1));
            ex_mem_read   = 1'($urandom_range(0, 1));
            mem_reg_write = 1'($urandom_range(0, 1));
            wb_reg_write  = 1'($urandom_range(0, 1));
            id_is_branch  = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            if (burst == 0 && $urandom_range(0, 15) == 0)
                burst = $urandom_range(1, 12);
            mem_busy = (burst > 0);
            if (burst > 0) burst--;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
